// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage: FSM state
// encoding, NOP bubble encoding and datapath widths.
package fetch_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;

  localparam logic [ILEN-1:0] NOP_ENCODING = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT   = 2'b00,
    RUN    = 2'b01,
    HALTED = 2'b10
  } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Priority is bubble > load > hold; hold is the
// stall case.
module if_id_reg
  import fetch_pkg::*;
#(
  parameter logic [ILEN-1:0] NOP_INSTR = NOP_ENCODING
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            bubble,
  input  logic [XLEN-1:0] next_pc,
  input  logic [ILEN-1:0] next_instr,
  output logic [XLEN-1:0] pc,
  output logic [ILEN-1:0] instr,
  output logic            valid
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc    <= '0;
      instr <= NOP_INSTR;
      valid <= 1'b0;
    end else if (bubble) begin
      pc    <= '0;
      instr <= NOP_INSTR;
      valid <= 1'b0;
    end else if (load) begin
      pc    <= next_pc;
      instr <= next_instr;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC mux, BOOT/RUN/HALTED FSM and
// fetch counter. Define FETCH_BOUND_CHECK_EN to add the fetch_fault output.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [ILEN-1:0] NOP_INSTR = NOP_ENCODING,
  parameter int unsigned     MEM_SIZE  = 4095
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] imem_addr,
  input  logic [ILEN-1:0] imem_instr,
  output logic [XLEN-1:0] if_id_pc,
  output logic [ILEN-1:0] if_id_instr,
  output logic            if_id_valid,
  output logic            halted,
  output logic [XLEN-1:0] fetch_count
`ifdef FETCH_BOUND_CHECK_EN
  ,
  output logic            fetch_fault
`endif
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] count_q;
  logic            ifid_load, ifid_bubble, count_inc;
  logic            out_of_range;
  logic [XLEN-1:0] target_pc;

  // Word-aligned target; no compressed instructions.
  assign target_pc = redirect_pc & ~64'h3;

`ifdef FETCH_BOUND_CHECK_EN
  logic fault_q;

  // 65-bit compare so a PC near 2^64 cannot wrap past the bound.
  assign out_of_range = ({1'b0, pc_q} + 65'd3) >= 65'(MEM_SIZE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      fault_q <= 1'b0;
    else if (redirect && state_q != BOOT)
      fault_q <= 1'b0;
    else if (state_q == RUN && !stall && out_of_range)
      fault_q <= 1'b1;
  end

  assign fetch_fault = fault_q;
`else
  logic unused_mem_size;

  assign out_of_range    = 1'b0;
  assign unused_mem_size = (MEM_SIZE != 0);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (count_inc) count_q <= count_q + 64'd1;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ifid_load   = 1'b0;
    ifid_bubble = 1'b0;
    count_inc   = 1'b0;
    unique case (state_q)
      BOOT: begin
        ifid_bubble = 1'b1;
        state_d     = RUN;
      end
      RUN: begin
        if (redirect) begin
          pc_d        = target_pc;
          ifid_bubble = 1'b1;
        end else if (stall) begin
          // hold everything
        end else if (imem_instr == '0 || out_of_range) begin
          state_d     = HALTED;
          ifid_bubble = 1'b1;
        end else begin
          pc_d      = pc_q + 64'd4;
          ifid_load = 1'b1;
          count_inc = 1'b1;
        end
      end
      HALTED: begin
        ifid_bubble = 1'b1;
        if (redirect) begin
          pc_d    = target_pc;
          state_d = RUN;
        end
      end
      default: begin
        ifid_bubble = 1'b1;
        state_d     = BOOT;
      end
    endcase
  end

  if_id_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id_reg (
    .clk       (clk),
    .reset     (reset),
    .load      (ifid_load),
    .bubble    (ifid_bubble),
    .next_pc   (pc_q),
    .next_instr(imem_instr),
    .pc        (if_id_pc),
    .instr     (if_id_instr),
    .valid     (if_id_valid)
  );

  assign imem_addr   = pc_q;
  assign halted      = (state_q == HALTED);
  assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, async reset
// check and a randomized run against a behavioural model.
module tb_fetch_stage;
  import fetch_pkg::*;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic [63:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic        halted;
  logic [63:0] fetch_count;
`ifdef FETCH_BOUND_CHECK_EN
  logic        fetch_fault;
`endif

  localparam int unsigned MEM_BYTES = 4095;

  int tests = 0;
  int fails = 0;

  // Instruction memory: every word nonzero except one programmable address.
  logic        zero_en;
  logic [63:0] zero_addr;

  function automatic logic [31:0] word_of(input logic [63:0] a);
    return (a[31:0] ^ 32'h5A3C_9E11) | 32'h1;
  endfunction

  function automatic logic [31:0] mem_read(input logic [63:0] a, input logic zen,
                                           input logic [63:0] zaddr);
    return (zen && a == zaddr) ? 32'h0 : word_of(a);
  endfunction

  assign imem_instr = mem_read(imem_addr, zero_en, zero_addr);

  fetch_stage #(
    .RESET_PC (64'h0),
    .NOP_INSTR(32'h0000_0013),
    .MEM_SIZE (MEM_BYTES)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_addr  (imem_addr),
    .imem_instr (imem_instr),
    .if_id_pc   (if_id_pc),
    .if_id_instr(if_id_instr),
    .if_id_valid(if_id_valid),
    .halted     (halted),
    .fetch_count(fetch_count)
`ifdef FETCH_BOUND_CHECK_EN
    ,
    .fetch_fault(fetch_fault)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Directed vectors: inputs held during a cycle, expected outputs after the edge.
  typedef struct {
    logic        stall;
    logic        redirect;
    logic [63:0] rpc;
    logic [63:0] exp_addr;
    logic [63:0] exp_if_pc;
    logic        exp_valid;
    logic        exp_halted;
    logic [63:0] exp_count;
    logic        exp_fault;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic s, input logic r, input logic [63:0] rpc,
                     input logic [63:0] addr, input logic [63:0] ifpc, input logic v,
                     input logic h, input logic [63:0] cnt, input logic f);
    vec_t e;
    e.stall = s; e.redirect = r; e.rpc = rpc; e.exp_addr = addr; e.exp_if_pc = ifpc;
    e.exp_valid = v; e.exp_halted = h; e.exp_count = cnt; e.exp_fault = f;
    vecs.push_back(e);
  endtask

  task automatic check_outputs(input string tag, input logic [63:0] addr,
                               input logic [63:0] ifpc, input logic [31:0] instr,
                               input logic v, input logic h, input logic [63:0] cnt,
                               input logic f);
    check({tag, " imem_addr"}, imem_addr, addr);
    check({tag, " if_id_pc"}, if_id_pc, ifpc);
    check({tag, " if_id_instr"}, 64'(if_id_instr), 64'(instr));
    check({tag, " if_id_valid"}, 64'(if_id_valid), 64'(v));
    check({tag, " halted"}, 64'(halted), 64'(h));
    check({tag, " fetch_count"}, fetch_count, cnt);
`ifdef FETCH_BOUND_CHECK_EN
    check({tag, " fetch_fault"}, 64'(fetch_fault), 64'(f));
`else
    if (f) check({tag, " fetch_fault_unexpected"}, 64'(f), 64'(0));
`endif
  endtask

  // Behavioural model: state of the fetch stage as described by its rules.
  logic        m_boot, m_halted, m_valid, m_fault;
  logic [63:0] m_pc, m_if_pc, m_count;
  logic [31:0] m_instr;

  task automatic model_reset();
    m_boot = 1; m_halted = 0; m_valid = 0; m_fault = 0;
    m_pc = 0; m_if_pc = 0; m_count = 0; m_instr = NOP_ENCODING;
  endtask

  task automatic model_bubble();
    m_valid = 0; m_if_pc = 0; m_instr = NOP_ENCODING;
  endtask

  task automatic model_edge();
    logic [31:0] w;
    logic        oob;
    w = mem_read(m_pc, zero_en, zero_addr);
`ifdef FETCH_BOUND_CHECK_EN
    oob = ({1'b0, m_pc} + 65'd3) >= 65'(MEM_BYTES);
`else
    oob = 0;
`endif
    if (m_boot) begin
      model_bubble();
      m_boot = 0;
    end else if (m_halted) begin
      model_bubble();
      if (redirect) begin
        m_pc = {redirect_pc[63:2], 2'b00};
        m_halted = 0;
        m_fault = 0;
      end
    end else if (redirect) begin
      m_pc = {redirect_pc[63:2], 2'b00};
      model_bubble();
      m_fault = 0;
    end else if (stall) begin
      // nothing moves
    end else if (w == 0 || oob) begin
      m_halted = 1;
      model_bubble();
      if (oob) m_fault = 1;
    end else begin
      m_if_pc = m_pc;
      m_instr = w;
      m_valid = 1;
      m_count = m_count + 1;
      m_pc = m_pc + 4;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1; stall = 0; redirect = 0; redirect_pc = 0;
    zero_en = 1; zero_addr = 64'h10;
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset", 64'h0, 64'h0, NOP_ENCODING, 0, 0, 64'd0, 0);

    //   stall redir rpc                      addr                     if_pc                    v  h  cnt f
    add(0, 0, 64'h0,                  64'h0,                  64'h0,                  0, 0, 0, 0); // BOOT
    add(0, 0, 64'h0,                  64'h4,                  64'h0,                  1, 0, 1, 0);
    add(0, 0, 64'h0,                  64'h8,                  64'h4,                  1, 0, 2, 0);
    add(1, 0, 64'h0,                  64'h8,                  64'h4,                  1, 0, 2, 0);
    add(1, 0, 64'h0,                  64'h8,                  64'h4,                  1, 0, 2, 0);
    add(1, 0, 64'h0,                  64'h8,                  64'h4,                  1, 0, 2, 0);
    add(0, 0, 64'h0,                  64'hC,                  64'h8,                  1, 0, 3, 0);
    add(1, 1, 64'h23,                 64'h20,                 64'h0,                  0, 0, 3, 0);
    add(0, 0, 64'h0,                  64'h24,                 64'h20,                 1, 0, 4, 0);
    add(0, 1, 64'h10,                 64'h10,                 64'h0,                  0, 0, 4, 0);
    add(0, 0, 64'h0,                  64'h10,                 64'h0,                  0, 1, 4, 0); // zero word
    add(1, 0, 64'h0,                  64'h10,                 64'h0,                  0, 1, 4, 0);
    add(0, 0, 64'h0,                  64'h10,                 64'h0,                  0, 1, 4, 0);
    add(0, 1, 64'h40,                 64'h40,                 64'h0,                  0, 0, 4, 0);
    add(0, 0, 64'h0,                  64'h44,                 64'h40,                 1, 0, 5, 0);
`ifdef FETCH_BOUND_CHECK_EN
    add(0, 1, 64'hFFC,                64'hFFC,                64'h0,                  0, 0, 5, 0);
    add(0, 0, 64'h0,                  64'hFFC,                64'h0,                  0, 1, 5, 1); // bound
    add(0, 1, 64'h100,                64'h100,                64'h0,                  0, 0, 5, 0);
`else
    add(0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0,                  0, 0, 5, 0);
    add(0, 0, 64'h0,                  64'h0,                  64'hFFFF_FFFF_FFFF_FFFC, 1, 0, 6, 0); // wrap
    add(0, 0, 64'h0,                  64'h4,                  64'h0,                  1, 0, 7, 0);
`endif

    @(negedge clk);
    reset = 0;
    foreach (vecs[i]) begin
      stall = vecs[i].stall;
      redirect = vecs[i].redirect;
      redirect_pc = vecs[i].rpc;
      @(posedge clk);
      #1;
      check_outputs($sformatf("vec%0d", i), vecs[i].exp_addr, vecs[i].exp_if_pc,
                    vecs[i].exp_valid ? word_of(vecs[i].exp_if_pc) : NOP_ENCODING,
                    vecs[i].exp_valid, vecs[i].exp_halted, vecs[i].exp_count,
                    vecs[i].exp_fault);
    end
    stall = 0; redirect = 0;

    // Asynchronous reset in the middle of a cycle takes effect immediately.
    @(posedge clk);
    #2 reset = 1;
    #1;
    check_outputs("async_reset", 64'h0, 64'h0, NOP_ENCODING, 0, 0, 64'd0, 0);
    @(negedge clk);
    reset = 0;
    model_reset();

    for (int i = 0; i < 600; i++) begin
      stall = ($urandom_range(0, 3) == 0);
      redirect = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 3))
        0: redirect_pc = 64'hFFFF_FFFF_FFFF_FFE0 | 64'($urandom_range(0, 31));
        1: redirect_pc = 64'h0000_0000_0000_0F00 | 64'($urandom_range(0, 255));
        default: redirect_pc = 64'($urandom_range(0, 1023));
      endcase
      if ($urandom_range(0, 15) == 0)
        zero_addr = m_pc + 64'(4 * $urandom_range(0, 3));
      model_edge();
      @(posedge clk);
      #1;
      check_outputs($sformatf("rnd%0d", i), m_pc, m_if_pc, m_instr, m_valid, m_halted,
                    m_count, m_fault);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the byte-addressed, big-endian, combinational-read instruction memory.
- Owns the PC register and drives the 64-bit fetch address.
- Captures the returned 32-bit instruction into the IF/ID pipeline register.
- Handles hazard stalls, branch redirects/flushes and end-of-program halt detection.

Parameters:
- RESET_PC, 64'h0, PC value loaded on reset.
- NOP_INSTR, 32'h00000013, bubble encoding (addi x0,x0,0) placed in IF/ID.
- MEM_SIZE, 4095, instruction-memory size in bytes; used only by the optional feature.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  hazard-unit stall; hold PC and IF/ID.
- redirect  input  1  branch/jump taken in EX; flush and load target.
- redirect_pc  input  64  redirect target.
- imem_addr  output  64  fetch address to instruction memory (= pc, combinational).
- imem_instr  input  32  instruction returned combinationally for imem_addr.
- if_id_pc  output  64  PC of the instruction held in IF/ID.
- if_id_instr  output  32  instruction held in IF/ID.
- if_id_valid  output  1  IF/ID holds a real instruction.
- halted  output  1  fetch has stopped on an all-zero word.
- fetch_count  output  64  number of valid instructions latched into IF/ID.

Behaviour:
- Reset (async, immediate):
  - pc=RESET_PC; if_id_pc=0; if_id_instr=NOP_INSTR; if_id_valid=0; halted=0; fetch_count=0.
  - FSM state = BOOT.
- FSM states are BOOT, RUN and HALTED. BOOT lasts exactly one cycle after reset deasserts:
  - IF/ID is loaded with a bubble.
  - pc holds.
  - Next state is RUN.
- Per-edge priority in RUN is reset > redirect > stall > zero-word halt > normal:
  - Redirect: pc <= {redirect_pc[63:2],2'b00} (low bits forced to zero, no compressed ISA). IF/ID gets a bubble (valid=0, instr=NOP_INSTR, pc=0). Redirect wins over a simultaneous stall.
  - Stall (no redirect): pc and all IF/ID fields hold their values.
  - Zero word (imem_instr==32'h0, no stall, no redirect): go to HALTED. pc holds. IF/ID gets a bubble. halted=1 from the next cycle.
  - Normal: pc <= pc+4, modulo 2^64 (wraps 64'hFFFF_FFFF_FFFF_FFFC -> 0). if_id_pc<=pc; if_id_instr<=imem_instr; if_id_valid<=1; fetch_count += 1.
- HALTED:
  - pc holds; IF/ID gets a bubble every cycle; stall is ignored.
  - A redirect loads the target, clears halted and returns to RUN. This lets an older branch still in flight recover from a wrong-path zero word.
- Latency: 1 cycle from imem_addr to IF/ID.
- fetch_count wraps silently at 2^64.
- Reset asserted mid-operation overrides everything asynchronously. No partial state survives.

Optional Feature:
- Macro FETCH_BOUND_CHECK_EN.
- When defined:
  - Add output fetch_fault (1 bit, reset 0).
  - In RUN, with no stall and no redirect, if pc+3 >= MEM_SIZE, treat the fetch like a zero word: enter HALTED, latch a bubble, set fetch_fault=1.
  - fetch_fault clears only on reset or redirect.
- When undefined: no fetch_fault port. Out-of-range addresses are fetched as-is.

Decomposition:
- Shared package fetch_pkg holds:
  - FSM state typedef (BOOT, RUN, HALTED) and its 2-bit encoding.
  - NOP encoding constant.
  - Instruction width (32) and address width (64) constants.
- One natural sub-module, if_id_reg: the IF/ID pipeline register with load, hold and bubble controls and async reset. fetch_stage contains the PC, next-PC mux, FSM and counter.

Test Plan:
- Reset released, imem words at 0,4,8 nonzero, no stall -> cycle 1 bubble (BOOT); then if_id_pc = 0, 4, 8 on successive edges; valid=1; fetch_count=3.
- Stall held for 3 cycles at pc=8 -> imem_addr stays 8; if_id_pc/instr unchanged; fetch_count unchanged; resume gives if_id_pc=8.
- Redirect and stall in the same cycle, redirect_pc=64'h23 -> next pc=64'h20; IF/ID bubble (valid=0, instr=32'h00000013); next edge latches if_id_pc=64'h20.
- imem returns 32'h0 at pc=64'h10 -> halted=1; pc stays 64'h10; bubbles continue. Then redirect_pc=64'h40 -> halted=0 and fetch resumes at 64'h40.
- pc preloaded via redirect to 64'hFFFF_FFFF_FFFF_FFFC with a nonzero word -> next pc=0.
- With FETCH_BOUND_CHECK_EN, MEM_SIZE=4095, redirect to 64'hFFC -> fetch_fault=1, halted=1, no valid instruction latched.
